// File: rtl/spi_flash_arbiter.sv
// Two-requester arbiter that runs each granted request as a flash READ (0x03) over SPI mode 0.
// Define SPI_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise req0 has fixed priority.
module spi_flash_arbiter #(
    parameter int SCLK_HALF = 1,
    parameter int CS_IDLE   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] addr0,
    input  logic [23:0] addr1,
    input  logic [7:0]  len0,
    input  logic [7:0]  len1,
    output logic        gnt0,
    output logic        gnt1,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic        rd_owner,
    output logic        busy,
    output logic        flash_sclk,
    output logic        flash_cs_n,
    output logic        flash_mosi,
    input  logic        flash_miso,
    output logic [2:0]  dbg_state
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CMD  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [7:0] CMD_READ = 8'h03;
    localparam int PW = $clog2(2 * SCLK_HALF);
    localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   hdr_q, hdr_d;
    logic [2:0]    bit_q, bit_d;
    logic [8:0]    bytes_q, bytes_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    sh_q, sh_d;
    logic          done_q, done_d;
    logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          owner_q, owner_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          win1;
    logic [23:0]   sel_addr;
    logic [7:0]    sel_len;

`ifdef SPI_ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    // On a tie the requester not served last wins; last_q resets to 1 so req0 takes the first tie.
    assign win1 = req1 & (~req0 | ~last_q);
`else
    assign win1 = req1 & ~req0;
`endif

    assign sel_addr = win1 ? addr1 : addr0;
    assign sel_len  = win1 ? len1 : len0;

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        cnt_d      = cnt_q;
        hdr_d      = hdr_q;
        bit_d      = bit_q;
        bytes_d    = bytes_q;
        gap_d      = gap_q;
        sh_d       = sh_q;
        done_d     = 1'b0;
        gnt0_d     = 1'b0;
        gnt1_d     = 1'b0;
        rd_valid_d = done_q;
        rd_data_d  = done_q ? sh_q : rd_data_q;
        owner_d    = owner_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
`ifdef SPI_ARB_ROUND_ROBIN_EN
        last_d     = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 | req1) begin
                    gnt0_d  = ~win1;
                    gnt1_d  = win1;
                    owner_d = win1;
                    // hdr holds the bits still to send after the one placed on MOSI now.
                    mosi_d  = CMD_READ[7];
                    hdr_d   = {CMD_READ[6:0], sel_addr, 1'b0};
                    bytes_d = (sel_len == 8'd0) ? 9'd256 : {1'b0, sel_len};
                    ph_d    = '0;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_CMD;
`ifdef SPI_ARB_ROUND_ROBIN_EN
                    last_d  = win1;
`endif
                end
            end
            S_CMD, S_ADDR, S_DATA: begin
                ph_d = ph_q + PW'(1);
                if (ph_q == PW'(SCLK_HALF - 1)) begin
                    sclk_d = 1'b1;
                    if (state_q == S_DATA) begin
                        sh_d   = {sh_q[6:0], flash_miso};
                        bit_d  = bit_q + 3'd1;
                        done_d = (bit_q == 3'd7);
                    end
                end
                if (ph_q == PW'(2 * SCLK_HALF - 1)) begin
                    ph_d   = '0;
                    sclk_d = 1'b0;
                    if (state_q != S_DATA) begin
                        cnt_d  = cnt_q + 5'd1;
                        mosi_d = hdr_q[31];
                        hdr_d  = {hdr_q[30:0], 1'b0};
                        if (cnt_q == 5'd7) state_d = S_ADDR;
                        if (cnt_q == 5'd31) begin
                            state_d = S_DATA;
                            mosi_d  = 1'b0;
                        end
                    end else if (bit_q == 3'd0) begin
                        // bit_q wrapped on this bit's sample: a whole byte has just finished.
                        bytes_d = bytes_q - 9'd1;
                        if (bytes_q == 9'd1) begin
                            state_d = S_GAP;
                            gap_d   = '0;
                        end
                    end
                end
            end
            S_GAP: begin
                if (gap_q == GW'(CS_IDLE - 1)) state_d = S_IDLE;
                else gap_d = gap_q + GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ph_q       <= '0;
            cnt_q      <= '0;
            hdr_q      <= '0;
            bit_q      <= '0;
            bytes_q    <= '0;
            gap_q      <= '0;
            sh_q       <= '0;
            done_q     <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            owner_q    <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            cnt_q      <= cnt_d;
            hdr_q      <= hdr_d;
            bit_q      <= bit_d;
            bytes_q    <= bytes_d;
            gap_q      <= gap_d;
            sh_q       <= sh_d;
            done_q     <= done_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            owner_q    <= owner_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
`ifdef SPI_ARB_ROUND_ROBIN_EN
            last_q     <= last_d;
`endif
        end
    end

    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign rd_owner   = owner_q;
    assign busy       = (state_q != S_IDLE);
    assign flash_cs_n = (state_q == S_IDLE) || (state_q == S_GAP);
    assign flash_sclk = sclk_q;
    assign flash_mosi = mosi_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_spi_flash_arbiter.sv
// Bench for spi_flash_arbiter: instance 0 uses SCLK_HALF=1, instance 1 uses SCLK_HALF=3 with a MISO glitch model.
module tb_spi_flash_arbiter;
    localparam int H0 = 1;
    localparam int H1 = 3;
    localparam int CSI = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_w, req0_w, req1_w;
    logic [1:0][23:0] addr0_w, addr1_w;
    logic [1:0][7:0]  len0_w, len1_w;
    logic [1:0]       gnt0_w, gnt1_w, rd_valid_w, rd_owner_w, busy_w;
    logic [1:0][7:0]  rd_data_w;
    logic [1:0]       sclk_w, cs_n_w, mosi_w;
    logic [1:0]       miso_w = '0;
    logic [1:0][2:0]  dbg_w;

    spi_flash_arbiter #(.SCLK_HALF(H0), .CS_IDLE(CSI)) u_dut0 (
        .clk(clk), .rst(rst_w[0]), .req0(req0_w[0]), .req1(req1_w[0]),
        .addr0(addr0_w[0]), .addr1(addr1_w[0]), .len0(len0_w[0]), .len1(len1_w[0]),
        .gnt0(gnt0_w[0]), .gnt1(gnt1_w[0]), .rd_data(rd_data_w[0]), .rd_valid(rd_valid_w[0]),
        .rd_owner(rd_owner_w[0]), .busy(busy_w[0]), .flash_sclk(sclk_w[0]), .flash_cs_n(cs_n_w[0]),
        .flash_mosi(mosi_w[0]), .flash_miso(miso_w[0]), .dbg_state(dbg_w[0]));

    spi_flash_arbiter #(.SCLK_HALF(H1), .CS_IDLE(CSI)) u_dut1 (
        .clk(clk), .rst(rst_w[1]), .req0(req0_w[1]), .req1(req1_w[1]),
        .addr0(addr0_w[1]), .addr1(addr1_w[1]), .len0(len0_w[1]), .len1(len1_w[1]),
        .gnt0(gnt0_w[1]), .gnt1(gnt1_w[1]), .rd_data(rd_data_w[1]), .rd_valid(rd_valid_w[1]),
        .rd_owner(rd_owner_w[1]), .busy(busy_w[1]), .flash_sclk(sclk_w[1]), .flash_cs_n(cs_n_w[1]),
        .flash_mosi(mosi_w[1]), .flash_miso(miso_w[1]), .dbg_state(dbg_w[1]));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0]  fdat [2][256];
    logic [31:0] hdr_cap [2];
    int cs_low_cnt [2], busy_cnt [2], rise_cnt [2], rd_cnt [2];
    int gnt_cyc [2], last_rise [2], low_cnt [2];
    bit prev_sclk [2];
    bit glitch_en [2];
    int model_last [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int hv(input int d);
        return (d == 0) ? H0 : H1;
    endfunction

    // Winner per the arbitration rule; model_last is the last requester served.
    function automatic int pick(input int d, input bit r0, input bit r1);
`ifdef SPI_ARB_ROUND_ROBIN_EN
        if (r0 && r1) return (model_last[d] == 0) ? 1 : 0;
`endif
        return r0 ? 0 : 1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor and flash model: sampled at negedge, away from the DUT's active edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int idx;
            logic [7:0] byte_v;
            logic b;
            if (gnt0_w[d] | gnt1_w[d]) begin
                gnt_cyc[d] = cyc; cs_low_cnt[d] = 0; busy_cnt[d] = 0;
                rise_cnt[d] = 0; rd_cnt[d] = 0; hdr_cap[d] = '0;
            end
            if (!cs_n_w[d]) cs_low_cnt[d]++;
            if (busy_w[d]) busy_cnt[d]++;
            if (sclk_w[d] && !prev_sclk[d]) begin
                if (rise_cnt[d] > 0) chk("sclk_period", cyc - last_rise[d], 2 * hv(d));
                if (rise_cnt[d] < 32) hdr_cap[d] = {hdr_cap[d][30:0], mosi_w[d]};
                else chk("mosi_data_low", {31'd0, mosi_w[d]}, 0);
                last_rise[d] = cyc;
                rise_cnt[d]++;
            end
            prev_sclk[d] = sclk_w[d];
            if (rd_valid_w[d]) begin
                chk("rd_data", {24'd0, rd_data_w[d]}, {24'd0, fdat[d][rd_cnt[d] & 255]});
                chk("rd_time", cyc - gnt_cyc[d], 79 * hv(d) + 1 + 16 * hv(d) * rd_cnt[d]);
                rd_cnt[d]++;
            end
            if (sclk_w[d]) low_cnt[d] = 0;
            else begin
                idx = rise_cnt[d] - 32;
                b = 1'b0;
                if (idx >= 0) begin
                    byte_v = fdat[d][(idx / 8) & 255];
                    b = byte_v[7 - (idx % 8)];
                end
                if (glitch_en[d] && low_cnt[d] == 0) b = ~b;
                miso_w[d] = b;
                low_cnt[d]++;
            end
        end
    end

    task automatic fill(input int d, input int n);
        for (int i = 0; i < n; i++) fdat[d][i] = 8'($urandom_range(0, 255));
    endtask

    // Waits for the next grant, checks it, then checks the whole transaction once busy drops.
    task automatic xfer(input int d, input int exp_who, input bit drop_at_gnt,
                        input bit drop_at_end, input int exp_lat);
        logic [23:0] ea;
        logic [7:0]  el;
        int L, h, n, lim;
        bit seen;
        ea = exp_who ? addr1_w[d] : addr0_w[d];
        el = exp_who ? len1_w[d] : len0_w[d];
        L = (el == 8'd0) ? 256 : int'(el);
        h = hv(d);
        seen = 0;
        n = 0;
        while (n < 40 && !seen) begin
            @(negedge clk);
            n++;
            if (gnt0_w[d] | gnt1_w[d]) seen = 1;
        end
        chk("gnt_seen", {31'd0, seen}, 1);
        if (!seen) return;
        if (exp_lat > 0) chk("gnt_latency", n, exp_lat);
        chk("gnt0", {31'd0, gnt0_w[d]}, (exp_who == 0) ? 1 : 0);
        chk("gnt1", {31'd0, gnt1_w[d]}, (exp_who == 1) ? 1 : 0);
        chk("rd_owner", {31'd0, rd_owner_w[d]}, exp_who);
        chk("cs_low_at_gnt", {31'd0, cs_n_w[d]}, 0);
        model_last[d] = exp_who;
        if (drop_at_gnt) begin
            if (exp_who == 0) req0_w[d] = 1'b0;
            else req1_w[d] = 1'b0;
        end
        lim = (32 + 8 * L) * 2 * h + CSI + 20;
        n = 0;
        while (n < lim && busy_w[d]) begin
            @(negedge clk);
            n++;
        end
        chk("busy_end", {31'd0, busy_w[d]}, 0);
        if (drop_at_end) begin
            req0_w[d] = 1'b0;
            req1_w[d] = 1'b0;
        end
        chk("mosi_header", hdr_cap[d], {8'h03, ea});
        chk("sclk_rises", rise_cnt[d], 32 + 8 * L);
        chk("cs_low_cycles", cs_low_cnt[d], (32 + 8 * L) * 2 * h);
        chk("busy_cycles", busy_cnt[d], (32 + 8 * L) * 2 * h + CSI);
        chk("strobe_count", rd_cnt[d], L);
    endtask

    task automatic check_reset_outputs(input int d);
        chk("rst_gnt0", {31'd0, gnt0_w[d]}, 0);
        chk("rst_gnt1", {31'd0, gnt1_w[d]}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid_w[d]}, 0);
        chk("rst_rd_data", {24'd0, rd_data_w[d]}, 0);
        chk("rst_rd_owner", {31'd0, rd_owner_w[d]}, 0);
        chk("rst_busy", {31'd0, busy_w[d]}, 0);
        chk("rst_sclk", {31'd0, sclk_w[d]}, 0);
        chk("rst_cs_n", {31'd0, cs_n_w[d]}, 1);
        chk("rst_mosi", {31'd0, mosi_w[d]}, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d, w;
        bit r0, r1;
        rst_w = 2'b11; req0_w = '0; req1_w = '0;
        addr0_w = '0; addr1_w = '0; len0_w = '0; len1_w = '0;
        glitch_en[0] = 0; glitch_en[1] = 0;
        model_last[0] = 1; model_last[1] = 1;
        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst_w = 2'b00;
        @(negedge clk);

        // Tie with both requests held across three transactions.
        fill(0, 8);
        addr0_w[0] = 24'($urandom); addr1_w[0] = 24'($urandom);
        len0_w[0] = 8'($urandom_range(1, 2)); len1_w[0] = 8'($urandom_range(1, 2));
        req0_w[0] = 1'b1; req1_w[0] = 1'b1;
        for (int k = 0; k < 3; k++) xfer(0, pick(0, 1, 1), 0, k == 2, -1);

        // Single read with known data.
        fdat[0][0] = 8'hA5; fdat[0][1] = 8'h3C;
        addr0_w[0] = 24'h123456; len0_w[0] = 8'd2; req0_w[0] = 1'b1;
        xfer(0, 0, 1, 0, 1);

        // Length 0 means 256 bytes.
        fill(0, 256);
        addr1_w[0] = 24'($urandom); len1_w[0] = 8'd0; req1_w[0] = 1'b1;
        xfer(0, 1, 1, 0, 1);

        // Reset during the address phase, then a clean restart.
        addr0_w[0] = 24'hABCDEF; len0_w[0] = 8'd2; req0_w[0] = 1'b1;
        w = 0;
        while (w < 10 && !gnt0_w[0]) begin
            @(negedge clk);
            w++;
        end
        chk("abort_gnt_seen", {31'd0, gnt0_w[0]}, 1);
        req0_w[0] = 1'b0;
        repeat (30) @(negedge clk);
        #1 rst_w[0] = 1'b1;
        #1 check_reset_outputs(0);
        repeat (3) @(negedge clk);
        chk("abort_no_valid", {31'd0, rd_valid_w[0]}, 0);
        rst_w[0] = 1'b0;
        model_last[0] = 1;
        @(negedge clk);
        fill(0, 4);
        addr0_w[0] = 24'h0F1E2D; len0_w[0] = 8'd3; req0_w[0] = 1'b1;
        xfer(0, 0, 1, 0, 1);

        // Slow SCLK with a glitch in each low half.
        glitch_en[1] = 1;
        fill(1, 1);
        addr0_w[1] = 24'($urandom); len0_w[1] = 8'd1; req0_w[1] = 1'b1;
        xfer(1, 0, 1, 0, 1);

        // Randomised requests on both instances.
        for (int k = 0; k < 8; k++) begin
            d = $urandom_range(0, 1);
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r1 = 1'b1;
            fill(d, 8);
            addr0_w[d] = 24'($urandom); addr1_w[d] = 24'($urandom);
            len0_w[d] = 8'($urandom_range(1, 4)); len1_w[d] = 8'($urandom_range(1, 4));
            req0_w[d] = r0; req1_w[d] = r1;
            w = pick(d, r0, r1);
            xfer(d, w, 1, 0, 1);
            if (r0 && r1) xfer(d, 1 - w, 1, 0, -1);
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/spi_flash_arbiter.md
# spi_flash_arbiter

Shares the board's single SPI configuration flash between two on-chip read requesters and sequences each access as a standard flash READ (0x03) transaction. Each request carries a 24-bit byte address and a byte count. The arbiter grants one requester, shifts out command and address, and streams the returned bytes back tagged with the owner. It sits between the core logic and the flash pins; `flash_sclk` drives the user-CCLK input of the configuration-clock primitive, and CS/MOSI/MISO go to pins.

## Interface
- `SCLK_HALF`, default 1: system-clock cycles per SCLK half-period (≥1).
- `CS_IDLE`, default 2: minimum system-clock cycles `flash_cs_n` stays high between transactions (≥1).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0`, `req1` in 1: read request; held high with address/length stable until the matching grant.
- `addr0`, `addr1` in 24: flash byte address.
- `len0`, `len1` in 8: byte count; 0 means 256.
- `gnt0`, `gnt1` out 1: one-cycle grant pulse; request fields latched that cycle.
- `rd_data` out 8: returned byte, MSB first from flash.
- `rd_valid` out 1: one-cycle strobe per byte.
- `rd_owner` out 1: requester index for current transaction, stable while `busy`.
- `busy` out 1: high from grant until CS idle time expires.
- `flash_sclk` out 1: SPI clock, mode 0 (idle low).
- `flash_cs_n` out 1: chip select, active low.
- `flash_mosi` out 1: serial data to flash.
- `flash_miso` in 1: serial data from flash; sampled raw, no synchroniser.

## Operation
- States: IDLE, CMD (8 bits, 0x03), ADDR (24 bits, MSB first), DATA (8·len bits), GAP (CS high for `CS_IDLE` cycles), then IDLE.
- IDLE with any request present:
  - Select the winner, pulse its `gnt`, latch its addr/len, set `rd_owner` and `busy`, drive `flash_cs_n` low.
  - Load the first MOSI bit (0x03 bit7 = 0) and enter CMD, all in the same cycle.
- Bit timing:
  - MOSI is valid for `SCLK_HALF` cycles before SCLK rises.
  - SCLK is high for `SCLK_HALF` cycles and low for `SCLK_HALF` cycles.
  - MOSI updates with the SCLK falling edge.
  - MISO is sampled into the shift register on the cycle SCLK rises.
- DATA: MOSI held 0. After the 8th sampled bit of each byte, `rd_data` loads and `rd_valid` pulses on the next cycle.
- After the last byte's final SCLK low half-period, `flash_cs_n` goes high and `busy` stays high through GAP.
- A request still high after its transaction completes counts as a new request.
- Byte counter is 9 bits internally; len 0 loads 256.
- Reset mid-transaction:
  - Immediate abort; no further `rd_valid`.
  - All outputs return to reset values; the pending requester must re-request.
- Reset values: `gnt0`=`gnt1`=0, `rd_valid`=0, `rd_data`=0x00, `rd_owner`=0, `busy`=0, `flash_sclk`=0, `flash_cs_n`=1, `flash_mosi`=0.

## Timing
- Grant latency: one cycle after `req` is first sampled high in IDLE. No grant while `busy`.
- CS-low duration: (32 + 8·len)·2·`SCLK_HALF` cycles, counted from the grant cycle.
- `busy` duration: CS-low duration + `CS_IDLE` cycles.
- First `rd_valid` at grant + (40·2·`SCLK_HALF` − `SCLK_HALF`) + 1 cycles. Subsequent strobes every 16·`SCLK_HALF` cycles.
- SCLK frequency = f_clk / (2·`SCLK_HALF`).

## Configuration
- `SPI_ARB_ROUND_ROBIN_EN` defined:
  - Round-robin; a last-served pointer picks the other requester on a simultaneous request.
  - Pointer resets to 1, so `req0` wins the first tie.
- `SPI_ARB_ROUND_ROBIN_EN` undefined: fixed priority, `req0` always wins ties; no pointer register.

## Test plan
- Reset check, `SCLK_HALF`=1: all outputs at reset values, SCLK idle.
- Single read: `req0`, `addr0`=0x123456, `len0`=2, flash model returns 0xA5, 0x3C.
  - MOSI bit stream 0x03,0x12,0x34,0x56.
  - `rd_valid` twice with 0xA5 then 0x3C, `rd_owner`=0.
  - CS low exactly 96 cycles; `busy` 98 cycles.
- Tie: `req0` and `req1` asserted the same cycle, then held.
  - With the macro: grants alternate 0,1,0.
  - Without the macro: `gnt0` every time, `req1` starved while `req0` is held.
- `len1`=0: exactly 256 `rd_valid` strobes, owner 1, CS low 4160 cycles.
- Reset mid-transaction: `rst` pulsed during ADDR → same cycle `flash_cs_n`=1, `busy`=0; next request restarts with command 0x03.
- `SCLK_HALF`=3, `len0`=1: SCLK period 6 cycles, CS low 240 cycles; MISO sampled only on SCLK rising cycles (glitch on a falling half ignored).
